// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package hilo_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/hilo_muldiv_if.sv
// ID-stage facing port bundle of the HI/LO multiply/divide unit.
interface hilo_muldiv_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            HIWrite;
  logic            LOWrite;
  logic [XLEN-1:0] HI_in;
  logic [XLEN-1:0] LO_in;
  logic [XLEN-1:0] HI;
  logic [XLEN-1:0] LO;
  logic            busy;
  logic            done;
  logic            stall;

  modport master (
    output start, op, src_a, src_b, HIWrite, LOWrite, HI_in, LO_in,
    input  HI, LO, busy, done, stall
  );

  modport slave (
    input  start, op, src_a, src_b, HIWrite, LOWrite, HI_in, LO_in,
    output HI, LO, busy, done, stall
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative datapath: shift-add multiply and restoring divide on magnitudes,
// one bit per run cycle, with sign fix-up applied combinationally in FIX.
module muldiv_seq
  import hilo_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic            run,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            last,
  output logic            res_valid,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);
  localparam int CW = $clog2(XLEN + 1);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              rem_neg_q, rem_neg_d;
  logic              res_valid_q, res_valid_d;

  logic              signed_op, div_op, a_neg, b_neg, div_zero;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [XLEN:0]     mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign last = (cnt_q == CW'(1));

  // Operand decode at accept: magnitudes and sign flags. A zero divisor keeps
  // the raw dividend and no sign flags, so the unsigned restoring loop yields
  // quotient all-ones and remainder equal to the dividend.
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    div_op    = (op == OP_DIV) || (op == OP_DIVU);
    div_zero  = div_op && (src_b == '0);
    a_neg     = signed_op && src_a[XLEN-1] && !div_zero;
    b_neg     = signed_op && src_b[XLEN-1] && !div_zero;
    a_abs     = a_neg ? -src_a : src_a;
    b_abs     = b_neg ? -src_b : src_b;
  end

  // One iteration of each algorithm on the current accumulator.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = rem_sh - {1'b0, opnd_q};
    div_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Next-state for operand registers, accumulator and down-counter.
  always_comb begin
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    neg_res_d   = neg_res_q;
    rem_neg_d   = rem_neg_q;
    res_valid_d = run && last;
    if (start) begin
      acc_d     = {{XLEN{1'b0}}, div_op ? a_abs : b_abs};
      opnd_d    = div_op ? b_abs : a_abs;
      cnt_d     = CW'(XLEN);
      is_div_d  = div_op;
      neg_res_d = a_neg ^ b_neg;
      rem_neg_d = div_op && a_neg;
    end else if (run) begin
      acc_d = is_div_q ? div_next : mul_next;
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Datapath registers; clear drops any partial result.
  always_ff @(posedge clk) begin
    if (clr) begin
      acc_q       <= '0;
      opnd_q      <= '0;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      neg_res_q   <= neg_res_d;
      rem_neg_q   <= rem_neg_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Sign fix-up of the finished accumulator.
  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    res_hi   = is_div_q ? rem_fix : prod_fix[2*XLEN-1:XLEN];
    res_lo   = is_div_q ? quo_fix : prod_fix[XLEN-1:0];
  end

  assign res_valid = res_valid_q;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with iterative multiply/divide and direct MTHI/MTLO.
//
// state | meaning
// IDLE  | accepts start and direct HI/LO writes
// RUN   | XLEN iterations in the datapath
// FIX   | sign fix-up, done pulse, HI/LO commit at closing edge
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           CLR,
  hilo_muldiv_if.slave  bus
);
  state_e          state_q, state_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            accept, run, busy, last, res_valid;
  logic [XLEN-1:0] res_hi, res_lo;

  assign accept = (state_q == IDLE) && bus.start;
  assign run    = (state_q == RUN);
  assign busy   = (state_q != IDLE);

  muldiv_seq #(.XLEN(XLEN)) u_seq (
    .clk       (clk),
    .clr       (CLR),
    .start     (accept),
    .run       (run),
    .op        (bus.op),
    .src_a     (bus.src_a),
    .src_b     (bus.src_b),
    .last      (last),
    .res_valid (res_valid),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  // Sequencing: accept in IDLE, leave RUN on terminal count, FIX lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Direct writes only while idle; the computed result wins at FIX.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == IDLE && bus.HIWrite) hi_d = bus.HI_in;
    if (state_q == IDLE && bus.LOWrite) lo_d = bus.LO_in;
    if (res_valid) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end
  end

  // State and HI/LO registers.
  always_ff @(posedge clk) begin
    if (CLR) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;
  assign bus.busy  = busy;
  assign bus.done  = (state_q == FIX);
  assign bus.stall = busy;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed plus random bench for hilo_muldiv with a result scoreboard.
module tb_hilo_muldiv;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic CLR;
  always #5 clk = ~clk;

  hilo_muldiv_if #(.XLEN(XLEN)) bus ();
  hilo_muldiv #(.XLEN(XLEN)) dut (.clk(clk), .CLR(CLR), .bus(bus));

  int checks = 0;
  int passed = 0;
  logic [31:0] q_hi[$];
  logic [31:0] q_lo[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    res = '0;
    case (op)
      2'd0: res = 64'(sa * sb);
      2'd1: res = 64'(ua * ub);
      default: begin
        if (b == 32'h0) begin
          res = {a, 32'hFFFFFFFF};
        end else begin
          q = (op == 2'd2) ? sa / sb : ua / ub;
          r = (op == 2'd2) ? sa % sb : ua % ub;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic clear_inputs();
    bus.start = 1'b0; bus.op = 2'd0; bus.src_a = '0; bus.src_b = '0;
    bus.HIWrite = 1'b0; bus.LOWrite = 1'b0; bus.HI_in = '0; bus.LO_in = '0;
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit inject, input bit mt_same);
    int n, done_at, done_cnt, stall_bad;
    logic [31:0] eh, el;
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    if (mt_same) begin bus.HIWrite = 1'b1; bus.HI_in = 32'h5A5A5A5A; end
    q_hi.push_back(exp_hi);
    q_lo.push_back(exp_lo);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.HIWrite = 1'b0;
    if (mt_same) check({tag, "_mthi_same_cycle"}, bus.HI, 32'h5A5A5A5A);
    n = 0; done_at = 0; done_cnt = 0; stall_bad = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
      if (bus.stall !== bus.busy) stall_bad++;
      if (inject && n == 3) begin
        bus.start = 1'b1; bus.op = 2'd3; bus.src_a = 32'd100; bus.src_b = 32'd3;
        bus.HIWrite = 1'b1; bus.LOWrite = 1'b1;
        bus.HI_in = 32'hDEADBEEF; bus.LO_in = 32'hDEADBEEF;
      end
      if (inject && n == 4) clear_inputs();
      @(posedge clk); #1;
    end
    check({tag, "_busy_cycles"}, n, XLEN + 1);
    check({tag, "_done_cycle"}, done_at, XLEN + 1);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_stall_eq_busy"}, stall_bad, 0);
    eh = q_hi.pop_front();
    el = q_lo.pop_front();
    check({tag, "_HI"}, bus.HI, eh);
    check({tag, "_LO"}, bus.LO, el);
    if (inject) begin
      @(posedge clk); #1;
      check({tag, "_no_second_op"}, bus.busy, 1'b0);
      check({tag, "_HI_held"}, bus.HI, eh);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] m;
    int dcnt, bcnt;

    clear_inputs();
    CLR = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_HI", bus.HI, 32'h0);
    check("rst_LO", bus.LO, 32'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_stall", bus.stall, 1'b0);
    CLR = 1'b0;
    @(posedge clk); #1;

    do_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1);
    do_op("mult_neg",  2'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
    do_op("mult_min",  2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
    do_op("div_neg",   2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    do_op("divu",      2'd3, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 1'b0);
    do_op("div_zero",  2'd2, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_op("divu_zero", 2'd3, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_op("div_min",   2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
    do_op("busy_rej",  2'd1, 32'd7,        32'd6,        32'd0,        32'd42,       1'b1, 1'b0);

    bus.HIWrite = 1'b1; bus.HI_in = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.HIWrite = 1'b0;
    check("mthi_HI", bus.HI, 32'hDEADBEEF);
    check("mthi_LO_kept", bus.LO, 32'd42);

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 2) ? 32'($urandom_range(1, 9)) : $urandom;
      m   = model(rop, ra, rb);
      do_op($sformatf("rand%0d", i), rop, ra, rb, m[63:32], m[31:0], 1'b0, 1'b0);
    end

    bus.HIWrite = 1'b1; bus.HI_in = 32'h11111111;
    bus.LOWrite = 1'b1; bus.LO_in = 32'h22222222;
    @(posedge clk); #1;
    clear_inputs();
    check("mtlo_LO", bus.LO, 32'h22222222);

    bus.start = 1'b1; bus.op = 2'd1; bus.src_a = 32'hFFFFFFFF; bus.src_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("clr_pre_busy", bus.busy, 1'b1);
    CLR = 1'b1;
    @(posedge clk); #1;
    CLR = 1'b0;
    check("clr_HI", bus.HI, 32'h0);
    check("clr_LO", bus.LO, 32'h0);
    check("clr_busy", bus.busy, 1'b0);
    check("clr_stall", bus.stall, 1'b0);
    check("clr_done", bus.done, 1'b0);
    dcnt = 0; bcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dcnt++;
      if (bus.busy === 1'b1) bcnt++;
    end
    check("clr_no_done", dcnt, 0);
    check("clr_no_busy", bcnt, 0);
    check("clr_HI_after", bus.HI, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
